config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports named clock and reset_n.
REQ-002 The module SHALL provide these parameters:
- NUM_WORDS, 50, configuration words per frame (LUT memory words plus switch-box configure words).
- DATA_W, 32, configuration word width.
- ADDR_W, 6, write-address width; NUM_WORDS SHALL be at most 2**ADDR_W.
REQ-003 The module SHALL provide these ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a configuration frame.
- in_valid  in  1  in_data holds a word.
- in_data  in  DATA_W  configuration or checksum word.
- in_ready  out  1  the loader accepts in_data this cycle.
- cfg_we  out  1  one-cycle write strobe into fabric configuration storage.
- cfg_addr  out  ADDR_W  word index 0..NUM_WORDS-1.
- cfg_data  out  DATA_W  word to write.
- busy  out  1  a frame is in progress.
- done  out  1  frame loaded and checksum matched.
- error  out  1  checksum mismatch.
- fabric_en  out  1  fabric is allowed to evaluate.

Function
REQ-004 The module SHALL implement the states IDLE, LOAD, CHECK, DONE and ERROR.
REQ-005 A word SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 only in LOAD and CHECK.
REQ-007 IDLE, DONE and ERROR SHALL go to LOAD on start=1; this clears the word counter, the XOR accumulator, done, error and fabric_en.
REQ-008 start SHALL be ignored in LOAD and CHECK.
REQ-009 In LOAD, each accepted word with index k SHALL produce, on the next cycle:
- cfg_we=1 for exactly one cycle;
- cfg_addr=k and cfg_data equal to the accepted word;
- acc = acc XOR word.
REQ-010 The LOAD-to-write latency SHALL be exactly 1 cycle, and back-to-back accepts SHALL produce back-to-back writes.
REQ-011 After word NUM_WORDS-1 is accepted, the state SHALL move to CHECK, and the counter SHALL NOT wrap or write beyond NUM_WORDS-1.
REQ-012 In CHECK, the next accepted word is the checksum; it SHALL NOT produce cfg_we.
REQ-013 If the checksum equals the final accumulator, the state SHALL go to DONE; otherwise it SHALL go to ERROR.
REQ-014 The final accumulator SHALL include word NUM_WORDS-1, even though its write occurs in the same cycle the checksum could be accepted.
REQ-015 busy SHALL be 1 in LOAD and CHECK, and 0 elsewhere.
REQ-016 done=1 and fabric_en=1 SHALL hold in DONE until start or reset.
REQ-017 error=1 SHALL hold in ERROR with fabric_en=0.
REQ-018 Idle cycles with in_valid=0 SHALL stall the frame indefinitely with no writes and no timeout.
REQ-019 in_data on cycles that are not accepted SHALL have no effect.

Reset
REQ-020 On reset_n=0 at a clock edge, the module SHALL enter IDLE and drive:
- in_ready=0, cfg_we=0, cfg_addr=0, cfg_data=0;
- busy=0, done=0, error=0, fabric_en=0;
- counter=0 and acc=0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame; no cfg_we SHALL be issued on the cycle after reset, even if a word was presented.
REQ-022 The first valid start after reset release SHALL be honoured.

Structure
REQ-023 The state encoding, NUM_WORDS, DATA_W and ADDR_W defaults SHALL reside in the shared package fpga_cfg_pkg for reuse by the fabric and benches.
REQ-024 The module SHALL be a single module with no sub-module; counter, accumulator, FSM and output registers SHALL all be local.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Full frame, no stalls: reset, start, 50 words where word k = 32'h1000_0000+k, then the correct XOR checksum. Required: 50 cfg_we pulses with addr 0..49 in order, each one cycle after its accept; done=1 and fabric_en=1 one cycle after the checksum is accepted.
- Bad checksum: same frame, checksum XOR 32'h1. Required: error=1, done=0, fabric_en=0; a following start clears error and returns busy=1.
- Stalls: in_valid toggled 1/0 every cycle. Required: exactly 50 writes with correct data; no cfg_we on stall cycles.
- Reset mid-frame: reset_n=0 after word 20. Required: all outputs 0 the next cycle; a new full frame then loads correctly from addr 0.
- Ignored inputs: start pulsed during LOAD, and in_valid=1 while IDLE. Required: no restart, no extra writes, in_ready=0 in IDLE.
- Reload: a second frame after DONE. Required: fabric_en drops to 0 at start and returns to 1 after the new checksum passes.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fabric configuration path: frame geometry
// defaults and the loader state encoding.
package fpga_cfg_pkg;

  localparam int NUM_WORDS_DEF = 50;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/config_loader.sv
// Streams one configuration frame into fabric storage, XOR-accumulating the
// words and validating them against a trailing checksum word.
module config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_en
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              cfg_we_q, cfg_we_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              fabric_en_q, fabric_en_d;
  logic              accept_s;

  // Next-state, write strobe and status computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    done_d      = done_q;
    error_d     = error_q;
    fabric_en_d = fabric_en_q;
    accept_s    = in_valid && in_ready_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LOAD;
          cnt_d       = '0;
          acc_d       = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          fabric_en_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          cfg_we_d   = 1'b1;
          cfg_addr_d = cnt_q;
          cfg_data_d = in_data;
          acc_d      = acc_q ^ in_data;
          // Counter parks on the last index rather than wrapping
          if (cnt_q == LAST_IDX) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CHECK: begin
        // acc_q already holds the last word: the checksum cannot be accepted
        // before the cycle after that word's accept
        if (accept_s) begin
          if (in_data == acc_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            fabric_en_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    busy_d     = in_ready_d;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      fabric_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      fabric_en_q <= fabric_en_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign fabric_en = fabric_en_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: full, bad-checksum, stalled, reset-abandoned,
// ignored-input and reload frames with hand-computed expectations.
module tb_config_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        fabric_en;

  int          n_chk;
  int          n_pass;
  int          we_count;
  logic [31:0] exp_acc;

  config_loader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .fabric_en(fabric_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count write strobes independently of the per-word checks
  always @(negedge clock) begin
    if (cfg_we === 1'b1) we_count <= we_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_acc = 32'h0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    chk("start_fab", {31'd0, fabric_en}, 32'd0);
    chk("start_err", {31'd0, error}, 32'd0);
    chk("start_done", {31'd0, done}, 32'd0);
  endtask

  task automatic load_words(input int first, input int last, input bit stall);
    logic [31:0] w;
    for (int k = first; k <= last; k++) begin
      w = 32'h1000_0000 + 32'(k);
      chk("pre_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      exp_acc  = exp_acc ^ w;
      cyc();
      chk("we", {31'd0, cfg_we}, 32'd1);
      chk("addr", {26'd0, cfg_addr}, 32'(k));
      chk("data", cfg_data, w);
      if (stall) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        cyc();
        chk("stall_we", {31'd0, cfg_we}, 32'd0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit bad);
    chk("ck_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = bad ? (exp_acc ^ 32'h1) : exp_acc;
    cyc();
    in_valid = 1'b0;
    chk("ck_we", {31'd0, cfg_we}, 32'd0);
    chk("ck_done", {31'd0, done}, bad ? 32'd0 : 32'd1);
    chk("ck_err", {31'd0, error}, bad ? 32'd1 : 32'd0);
    chk("ck_fab", {31'd0, fabric_en}, bad ? 32'd0 : 32'd1);
    chk("ck_busy", {31'd0, busy}, 32'd0);
    chk("ck_ready0", {31'd0, in_ready}, 32'd0);
    chk("we_count", 32'(we_count), 32'd50);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {in_ready, cfg_we, busy, done, error, fabric_en, 26'd0}, 32'd0);
    chk({tag, "_addr"}, {26'd0, cfg_addr}, 32'd0);
    chk({tag, "_data"}, cfg_data, 32'd0);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    we_count = 0;
    exp_acc  = 32'h0;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (3) cyc();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Words offered in IDLE are ignored
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    repeat (3) begin
      cyc();
      chk("idle_ready", {31'd0, in_ready}, 32'd0);
      chk("idle_we", {31'd0, cfg_we}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    in_valid = 1'b0;
    chk("idle_wecnt", 32'(we_count), 32'd0);

    // Full frame, no stalls
    we_count = 0;
    do_start();
    load_words(0, 49, 1'b0);
    finish_frame(1'b0);
    repeat (4) cyc();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_fab", {31'd0, fabric_en}, 32'd1);

    // Reload after DONE
    we_count = 0;
    do_start();
    load_words(0, 49, 1'b0);
    finish_frame(1'b0);

    // Bad checksum, then restart
    we_count = 0;
    do_start();
    load_words(0, 49, 1'b0);
    finish_frame(1'b1);
    repeat (2) cyc();
    chk("hold_err", {31'd0, error}, 32'd1);

    // Restart from ERROR with a stalled frame
    we_count = 0;
    do_start();
    load_words(0, 49, 1'b1);
    finish_frame(1'b0);

    // start pulsed mid-LOAD is ignored
    we_count = 0;
    do_start();
    load_words(0, 9, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_start_busy", {31'd0, busy}, 32'd1);
    chk("ign_start_we", {31'd0, cfg_we}, 32'd0);
    load_words(10, 49, 1'b0);
    finish_frame(1'b0);

    // Reset after word 20 with word 21 presented
    we_count = 0;
    do_start();
    load_words(0, 20, 1'b0);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1000_0015;
    cyc();
    in_valid = 1'b0;
    chk_all_zero("midrst");
    reset_n = 1'b1;
    cyc();
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    we_count = 0;
    do_start();
    load_words(0, 49, 1'b0);
    finish_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
